// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states, frame bytes, checksum.
// No logic here; latency and backpressure are defined by the modules that import it.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_ADDR = 2'd2,
    GOT_DATA = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;

  // Frame checksum: 8-bit sum of ADDR and DATA, wrapping.
  function automatic logic [7:0] chk8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter: clear reloads load_val, en counts down, expire pulses once on reaching zero.
// Expire is combinational in the zero cycle and suppressed by clear; no backpressure.
module uart_cmd_timeout #(
  parameter int WIDTH = 13
) (
  input  logic             hwclk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;
  logic             armed;

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (expire) begin
      armed <= 1'b0;
    end else if (en && cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // armed keeps expire to a single pulse per load even if en stays high
  assign expire = en && armed && !clear && (cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/DATA/CHK frames into an 8-bit register file; write strobe 1 cycle after CHK; optional UART_CMD_ACK_EN ack port.
// Input bytes cannot be stalled; the ack output holds until ack_ready and is overwritten by newer acks.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         NUM_REGS       = 4,
  parameter int         ADDR_W         = 2,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 5000
) (
  input  logic              hwclk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic [7:0]        led,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        err_count,
  output logic              busy
`ifdef UART_CMD_ACK_EN
  ,
  output logic              ack_valid,
  output logic [7:0]        ack_data,
  input  logic              ack_ready
`endif
);

  localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_t     state, state_nxt;
  logic [7:0] addr_q, data_q;
  logic [7:0] regs [NUM_REGS];
  logic       commit, bad_frame, abort, tmo_clear, tmo_expire, err_inc;

  uart_cmd_timeout #(.WIDTH(TMO_W)) u_timeout (
    .hwclk    (hwclk),
    .resetn   (resetn),
    .clear    (tmo_clear),
    .en       (busy),
    .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
    .expire   (tmo_expire)
  );

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rx_valid && rx_data == SYNC_BYTE) state_nxt = GOT_SYNC;
      GOT_SYNC: if (rx_valid) state_nxt = GOT_ADDR;
      GOT_ADDR: if (rx_valid) state_nxt = GOT_DATA;
      GOT_DATA: if (rx_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (state != IDLE && !rx_valid && (rx_frame_err || tmo_expire)) state_nxt = IDLE;
  end

  // A byte in the expiry cycle wins over the timeout because it is checked first.
  always_comb begin
    commit    = 1'b0;
    bad_frame = 1'b0;
    abort     = 1'b0;
    tmo_clear = 1'b0;
    if (state == IDLE) begin
      tmo_clear = rx_valid && (rx_data == SYNC_BYTE);
    end else if (rx_valid) begin
      tmo_clear = 1'b1;
      if (state == GOT_DATA) begin
        if (rx_data == chk8(addr_q, data_q) && addr_q < NUM_REGS_B) commit = 1'b1;
        else                                                        bad_frame = 1'b1;
      end
    end else if (rx_frame_err || tmo_expire) begin
      abort = 1'b1;
    end
  end

  assign err_inc = bad_frame || abort;
  assign busy    = (state != IDLE);
  assign led     = regs[0];

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      data_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= commit;
      if (state == GOT_SYNC && rx_valid) addr_q <= rx_data;
      if (state == GOT_ADDR && rx_valid) data_q <= rx_data;
      if (commit) begin
        regs[addr_q[ADDR_W-1:0]] <= data_q;
        wr_addr                  <= addr_q[ADDR_W-1:0];
        wr_data                  <= data_q;
      end
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

`ifdef UART_CMD_ACK_EN
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      ack_valid <= 1'b0;
      ack_data  <= '0;
    end else if (commit || bad_frame) begin
      ack_valid <= 1'b1;
      ack_data  <= commit ? ACK_BYTE : NAK_BYTE;
    end else if (ack_valid && ack_ready) begin
      ack_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser; ack checks are compiled in with UART_CMD_ACK_EN.
module tb_uart_cmd_parser;

  logic       hwclk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic [7:0] led;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] err_count;
  logic       busy;
`ifdef UART_CMD_ACK_EN
  logic       ack_valid;
  logic [7:0] ack_data;
  logic       ack_ready;
`endif

  always #5 hwclk = ~hwclk;

  uart_cmd_parser dut (
    .hwclk        (hwclk),
    .resetn       (resetn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .led          (led),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .err_count    (err_count),
    .busy         (busy)
`ifdef UART_CMD_ACK_EN
    ,
    .ack_valid    (ack_valid),
    .ack_data     (ack_data),
    .ack_ready    (ack_ready)
`endif
  );

  typedef struct {
    logic [31:0] frame;
    logic        exp_stb;
    logic [1:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  exp_led;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_err    = 0;
  int   stb_cnt  = 0;
  int   stb0;
  logic [7:0] exp_err;

  always @(negedge hwclk) if (wr_strobe === 1'b1) stb_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 3; i >= 0; i--) send_byte(f[8*i +: 8]);
  endtask

  task automatic pulse_frame_err();
    rx_frame_err = 1'b1;
    tick();
    rx_frame_err = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA5003C3C, 1'b1, 2'd0, 8'h3C, 8'h3C, 8'h00};
    vecs[1] = '{32'hA502FF01, 1'b1, 2'd2, 8'hFF, 8'h3C, 8'h00};
    vecs[2] = '{32'hA5011000, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h01};
    vecs[3] = '{32'hA5050106, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h02};
    vecs[4] = '{32'hA5A5A54A, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h03};
    vecs[5] = '{32'hA503A5A8, 1'b1, 2'd3, 8'hA5, 8'h3C, 8'h03};
    vecs[6] = '{32'hA500FFFF, 1'b1, 2'd0, 8'hFF, 8'hFF, 8'h03};

    resetn       = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    rx_frame_err = 1'b0;
`ifdef UART_CMD_ACK_EN
    ack_ready    = 1'b0;
`endif
    repeat (3) tick();
    check("reset led", led, 8'h00);
    check("reset wr_strobe", wr_strobe, 1'b0);
    check("reset wr_addr", wr_addr, 2'd0);
    check("reset wr_data", wr_data, 8'h00);
    check("reset err_count", err_count, 8'h00);
    check("reset busy", busy, 1'b0);
`ifdef UART_CMD_ACK_EN
    check("reset ack_valid", ack_valid, 1'b0);
    check("reset ack_data", ack_data, 8'h00);
`endif
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      stb0 = stb_cnt;
      send_frame(vecs[i].frame);
      check($sformatf("v%0d wr_strobe", i), wr_strobe, vecs[i].exp_stb);
      if (vecs[i].exp_stb) begin
        check($sformatf("v%0d wr_addr", i), wr_addr, vecs[i].exp_addr);
        check($sformatf("v%0d wr_data", i), wr_data, vecs[i].exp_data);
      end
      check($sformatf("v%0d led", i), led, vecs[i].exp_led);
      check($sformatf("v%0d err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("v%0d busy", i), busy, 1'b0);
      tick();
      check($sformatf("v%0d strobe drop", i), wr_strobe, 1'b0);
      check($sformatf("v%0d strobe count", i), stb_cnt - stb0, 32'(vecs[i].exp_stb));
    end
    exp_err = 8'h03;

    // back-to-back: second SYNC lands in the commit-strobe cycle of the first frame
    stb0 = stb_cnt;
    send_frame(32'hA5010203);
    check("b2b first strobe", wr_strobe, 1'b1);
    check("b2b first addr", wr_addr, 2'd1);
    check("b2b first data", wr_data, 8'h02);
    send_frame(32'hA5001111);
    check("b2b second strobe", wr_strobe, 1'b1);
    check("b2b second data", wr_data, 8'h11);
    tick();
    check("b2b led", led, 8'h11);
    check("b2b strobe count", stb_cnt - stb0, 2);
    check("b2b err_count", err_count, exp_err);

    // frame error aborts a frame in progress
    stb0 = stb_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    check("ferr busy before", busy, 1'b1);
    pulse_frame_err();
    exp_err++;
    check("ferr busy after", busy, 1'b0);
    check("ferr err_count", err_count, exp_err);

    // idle noise and idle frame errors change nothing
    send_byte(8'h12);
    send_byte(8'h34);
    pulse_frame_err();
    tick();
    check("noise busy", busy, 1'b0);
    check("noise led", led, 8'h11);
    check("noise err_count", err_count, exp_err);
    check("noise strobe count", stb_cnt - stb0, 0);

    // timeout: expiry cycle is TIMEOUT_CYCLES-1 cycles after entering GOT_SYNC
    send_byte(8'hA5);
    repeat (4998) tick();
    check("tmo busy at 4998", busy, 1'b1);
    tick();
    check("tmo busy in expiry cycle", busy, 1'b1);
    check("tmo err before", err_count, exp_err);
    tick();
    exp_err++;
    check("tmo busy after", busy, 1'b0);
    check("tmo err_count", err_count, exp_err);

    // byte in the expiry cycle wins
    send_byte(8'hA5);
    repeat (4999) tick();
    send_byte(8'h02);
    check("tmo race busy", busy, 1'b1);
    check("tmo race err_count", err_count, exp_err);
    send_byte(8'h03);
    send_byte(8'h05);
    check("tmo race strobe", wr_strobe, 1'b1);
    check("tmo race addr", wr_addr, 2'd2);
    check("tmo race data", wr_data, 8'h03);
    tick();

`ifdef UART_CMD_ACK_EN
    send_frame(32'hA5000101);
    check("ack valid", ack_valid, 1'b1);
    check("ack data", ack_data, 8'h06);
    check("ack strobe", wr_strobe, 1'b1);
    tick();
    check("ack led", led, 8'h01);
    send_frame(32'hA5011000);
    exp_err++;
    check("nak data", ack_data, 8'h15);
    check("nak valid held", ack_valid, 1'b1);
    check("nak err_count", err_count, exp_err);
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    check("ack drained", ack_valid, 1'b0);
    tick();
    check("ack stays low", ack_valid, 1'b0);
`endif

    // saturation
    repeat (300) send_frame(32'hA5011000);
    check("sat err_count", err_count, 8'hFF);
    send_frame(32'hA5011000);
    check("sat hold", err_count, 8'hFF);
    check("sat busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Downstream consumer of the 4x-oversampling UART receiver. Takes its per-byte strobe and data, parses fixed 4-byte command frames (SYNC, ADDR, DATA, CHK), and commits writes into a small 8-bit register file. Register 0 drives the 8 board LEDs. Runs on the 12 MHz board clock. Malformed, aborted and stalled frames are counted in a saturating error counter.

Parameters:
NUM_REGS, 4, number of 8-bit registers; legal ADDR values are 0..NUM_REGS-1
ADDR_W, 2, width of wr_addr; must satisfy 2**ADDR_W >= NUM_REGS
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 5000, maximum hwclk cycles allowed between bytes inside a frame (about 4.8 byte times at 115200 baud)

Ports:
hwclk  in  1  system clock, 12 MHz
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte with a good stop bit
rx_data  in  8  received byte; sampled only when rx_valid=1
rx_frame_err  in  1  one-cycle strobe: receiver saw a bad stop bit
led  out  8  current value of regs[0]
wr_strobe  out  1  one-cycle pulse when a write commits
wr_addr  out  ADDR_W  address of the committed write; valid while wr_strobe=1
wr_data  out  8  data of the committed write; valid while wr_strobe=1
err_count  out  8  saturating error counter
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all regs=0; led=0; wr_strobe=0; wr_addr=0; wr_data=0; err_count=0; timeout counter=0; busy=0.
- rx_valid and rx_frame_err are never both high in the same cycle; the bench enforces this.
- States are IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA. All transitions are registered.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE: go to GOT_SYNC.
  - Any other byte: ignored, no error counted.
  - rx_frame_err: ignored.
- GOT_SYNC:
  - rx_valid: latch addr_q=rx_data, go to GOT_ADDR.
  - A SYNC_BYTE value here is ordinary data; there is no mid-frame resync.
- GOT_ADDR:
  - rx_valid: latch data_q=rx_data, go to GOT_DATA.
- GOT_DATA, on rx_valid: compute chk=(addr_q+data_q) mod 256, 8-bit wraparound.
  - If rx_data==chk and addr_q<NUM_REGS: commit. regs[addr_q]<=data_q.
  - Otherwise: err_count increments.
  - Either way, go to IDLE.
- Commit timing: wr_strobe, wr_addr and wr_data are registered. wr_strobe goes high exactly 1 cycle after the rx_valid of the CHK byte, for 1 cycle. led changes in that same cycle when addr_q==0.
- rx_frame_err in any non-IDLE state: abort to IDLE, err_count increments, no write.
- Timeout:
  - The counter clears on entry to GOT_SYNC and on every accepted byte.
  - It increments each cycle while the state is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: go to IDLE, err_count increments.
  - If rx_valid arrives in the expiry cycle, the byte wins and no timeout occurs.
- err_count saturates at 8'hFF and never wraps.
- Only one error source can occur per cycle, so the increment is at most 1.
- Back-to-back frames: a SYNC byte arriving in the cycle after the commit is accepted normally.

Optional Feature:
UART_CMD_ACK_EN:
- When defined, adds three ports: ack_valid out 1, ack_data out 8, ack_ready in 1.
- On commit: ack_data=8'h06 (ACK), ack_valid=1, asserted in the same cycle as wr_strobe.
- On a checksum or address error in GOT_DATA: ack_data=8'h15 (NAK).
- No ack is produced for timeouts or frame errors.
- ack_valid holds until the cycle after ack_valid && ack_ready.
- A new ack while one is pending overwrites ack_data and keeps ack_valid=1.
- Reset: ack_valid=0, ack_data=0.
- When not defined: the ports and logic are absent, and parsing behaviour is otherwise identical.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA)
  - SYNC_BYTE default
  - ACK_BYTE=8'h06
  - NAK_BYTE=8'h15
  - a checksum function (8-bit sum)
- One sub-module, uart_cmd_timeout: a loadable down-counter with a clear input and a one-cycle expire output. It is reused later by the TX side.

Test Plan:
- Reset then frame A5 00 3C 3C → wr_strobe 1 cycle after the last rx_valid; wr_addr=0, wr_data=3C; led=3C; err_count=0.
- Frame A5 02 FF 01 (checksum wraps: 02+FF=01) → regs[2]=FF, led unchanged, wr_strobe=1 once.
- Bad checksum A5 01 10 00 → no wr_strobe, err_count=1. Then A5 05 01 06 (addr out of range) → no write, err_count=2.
- Frame errors and idle noise:
  - A5 01, then rx_frame_err → IDLE, err_count+1, busy=0.
  - Bytes 12 34 in IDLE → no change to any output.
- Timeouts:
  - A5, then no byte for 5000 cycles → IDLE exactly at cycle TIMEOUT_CYCLES-1, err_count+1.
  - A byte arriving exactly in the expiry cycle → accepted, no error.
  - 300 bad frames → err_count holds at FF.
- ACK path, with UART_CMD_ACK_EN defined and ack_ready=0:
  - A5 00 01 01 → ack_valid=1, ack_data=06.
  - Then a bad frame → ack_data=15, ack_valid still 1.
  - Then ack_ready=1 for 1 cycle → ack_valid=0 the next cycle.
